// File: rtl/stream_scan_ctrl_pkg.sv
// Shared types and constants for the stream scan controller.
// Pattern, state encoding and default widths.
package stream_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    DRAIN,
    DONE
  } state_e;

  localparam logic [5:0] PATTERN     = 6'b101011;
  localparam int         PATTERN_LEN = 6;
  localparam int         DEF_COUNT_W = 8;
  localparam int         DEF_WORD_W  = 8;

endpackage

// File: rtl/stream_scan_ctrl_if.sv
// Word stream handshake between a producer and the scanner.
// Producer drives the word, scanner drives ready.
interface stream_scan_ctrl_if
  import stream_scan_ctrl_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
);

  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_last;
  logic              word_ready;

  modport master (
    output word_in,
    output word_valid,
    output word_last,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_valid,
    input  word_last,
    output word_ready
  );

endinterface

// File: rtl/stream_scan_ctrl_matcher.sv
// Serial matcher for the fixed pattern, overlaps allowed.
// Progress = number of pattern bits currently matched.
module pattern_matcher
  import stream_scan_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic hit
);

  logic [2:0] prog_q, prog_d;
  logic       hit_q, hit_d;

  // Next progress on each enabled bit, falling back to the
  // longest prefix that is still a suffix of the bits seen.
  always_comb begin
    prog_d = prog_q;
    hit_d  = 1'b0;
    if (clr) begin
      prog_d = '0;
    end else if (en) begin
      unique case (prog_q)
        3'd0:    prog_d = bit_in ? 3'd1 : 3'd0;
        3'd1:    prog_d = bit_in ? 3'd1 : 3'd2;
        3'd2:    prog_d = bit_in ? 3'd3 : 3'd0;
        3'd3:    prog_d = bit_in ? 3'd1 : 3'd4;
        3'd4:    prog_d = bit_in ? 3'd5 : 3'd0;
        3'd5:    prog_d = bit_in ? 3'd6 : 3'd4;
        3'd6:    prog_d = bit_in ? 3'd1 : 3'd2;
        default: prog_d = '0;
      endcase
      hit_d = (prog_d == 3'(PATTERN_LEN));
    end
  end

  // Progress and registered one-cycle hit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prog_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      prog_q <= prog_d;
      hit_q  <= hit_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/stream_scan_ctrl.sv
// Job controller: loads words, serializes them MSB-first into
// the matcher and counts matches with saturation.
module stream_scan_ctrl
  import stream_scan_ctrl_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W,
  parameter int WORD_W  = DEF_WORD_W
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  stream_scan_ctrl_if.slave  s,
  output logic               busy,
  output logic               match_pulse,
  output logic [COUNT_W-1:0] match_count,
  output logic               done
);

  localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WORD_W - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               last_q, last_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               clr, en, hit, ready;

  pattern_matcher u_matcher (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .en     (en),
    .bit_in (word_q[WORD_W-1]),
    .hit    (hit)
  );

  // Next state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    last_d  = last_q;
    count_d = count_q;
    clr     = 1'b0;
    en      = 1'b0;
    ready   = 1'b0;
    done    = 1'b0;
    if (hit && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          clr     = 1'b1;
          count_d = '0;
        end
      end
      LOAD: begin
        ready = 1'b1;
        if (s.word_valid) begin
          word_d  = s.word_in;
          last_d  = s.word_last;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        en     = 1'b1;
        word_d = word_q << 1;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = last_q ? DRAIN : LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign s.word_ready = ready;
  assign busy         = (state_q != IDLE);
  assign match_pulse  = hit;
  assign match_count  = count_q;

endmodule

// File: tb/tb_stream_scan_ctrl.sv
// Scoreboard bench for stream_scan_ctrl.
// Stimulus pushes expected job results; monitor checks at done.
module tb_stream_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       busy, match_pulse, done;
  logic [7:0] match_count;

  stream_scan_ctrl_if #(.WORD_W(8)) sif ();

  stream_scan_ctrl #(.COUNT_W(8), .WORD_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .s           (sif),
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pulses;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  logic prev_done = 1'b0;

  function automatic void chk(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  // Reference: slide a 6-bit window over the MSB-first bit stream.
  function automatic int count_matches(input logic [7:0] w[$]);
    logic       b[$];
    logic [5:0] win;
    int         m;
    m = 0;
    foreach (w[i]) for (int k = 7; k >= 0; k--) b.push_back(w[i][k]);
    for (int i = 0; i + 6 <= b.size(); i++) begin
      for (int k = 0; k < 6; k++) win[5-k] = b[i+k];
      if (win == 6'b101011) m++;
    end
    return m;
  endfunction

  // Monitor: count pulses, check results whenever done fires.
  always @(negedge clk) begin
    if (!reset) begin
      pulses = 0;
      prev_done = 1'b0;
    end else begin
      if (match_pulse) pulses++;
      if (done) begin
        if (prev_done) chk("done_width", 2, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_count", int'(match_count), e.cnt);
          chk("done_pulses", pulses, e.pulses);
        end
        pulses = 0;
      end
      prev_done = done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic l);
    bit got;
    got = 0;
    sif.word_in    = w;
    sif.word_last  = l;
    sif.word_valid = 1'b1;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (sif.word_ready) got = 1;
      step();
    end
    sif.word_valid = 1'b0;
    if (!got) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    if (!ok) chk("busy_timeout", 0, 1);
    step();
  endtask

  task automatic run_job(input logic [7:0] w[$], input int smin,
                         input int smax, input bit garbage);
    exp_t e;
    int   m;
    m = count_matches(w);
    e.pulses = m;
    e.cnt = (m > 255) ? 255 : m;
    exp_q.push_back(e);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    foreach (w[i]) begin
      repeat ($urandom_range(smax, smin)) step();
      send_word(w[i], i == w.size() - 1);
      if (garbage) begin
        sif.word_in    = 8'hAC;
        sif.word_last  = 1'b1;
        sif.word_valid = 1'b1;
        start          = 1'b1;
        step();
        step();
        sif.word_valid = 1'b0;
        start          = 1'b0;
      end
    end
    wait_idle();
    repeat (3) step();
    @(negedge clk);
    chk("idle_hold", int'(match_count), e.cnt);
  endtask

  logic [7:0] wq[$];
  logic [7:0] pick[5];

  initial begin
    sif.word_in    = '0;
    sif.word_valid = 1'b0;
    sif.word_last  = 1'b0;
    pick = '{8'hAC, 8'hAD, 8'h56, 8'h2B, 8'h00};

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(sif.word_ready), 0);
    chk("rst_pulse", int'(match_pulse), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(match_count), 0);
    step();
    reset = 1'b1;
    step();

    wq = '{8'hAC};
    run_job(wq, 0, 0, 0);
    wq = '{8'hAD, 8'h60};
    run_job(wq, 0, 0, 0);
    wq = '{8'hAD, 8'h60};
    run_job(wq, 5, 5, 0);
    wq = '{8'hAD, 8'h60, 8'hAC};
    run_job(wq, 0, 2, 1);

    wq.delete();
    for (int i = 0; i < 260; i++) wq.push_back(8'hAC);
    run_job(wq, 0, 0, 0);

    for (int j = 0; j < 10; j++) begin
      wq.delete();
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) begin
        if ($urandom_range(1, 0) == 1) wq.push_back(8'($urandom));
        else wq.push_back(pick[$urandom_range(4, 0)]);
      end
      run_job(wq, 0, 3, $urandom_range(1, 0) == 1);
    end

    // Abandon a job in the middle of its second word.
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    send_word(8'hAD, 1'b0);
    send_word(8'h60, 1'b1);
    step();
    step();
    @(negedge clk);
    chk("pre_rst_count", int'(match_count), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_count", int'(match_count), 0);
    chk("arst_pulse", int'(match_pulse), 0);
    chk("arst_ready", int'(sif.word_ready), 0);
    step();
    step();
    reset = 1'b1;
    step();
    wq = '{8'h00};
    run_job(wq, 0, 1, 0);

    for (int t = 0; t < 200 && exp_q.size() != 0; t++) step();
    chk("pending_jobs", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_scan_ctrl.md
STREAM_SCAN_CTRL -- requirements
Module: stream_scan_ctrl

Interface
REQ-001 Parameter: COUNT_W, 8, width of match counter.
REQ-002 Parameter: WORD_W, 8, width of input word; bits serialized MSB-first.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 start  in  1  begin a scan job; sampled only in IDLE.
REQ-006 word_in  in  WORD_W  data word.
REQ-007 word_valid  in  1  word_in/word_last valid.
REQ-008 word_last  in  1  final word of job; qualified by word_valid.
REQ-009 word_ready  out  1  controller accepts word this cycle.
REQ-010 busy  out  1  job in progress (any state but IDLE).
REQ-011 match_pulse  out  1  one-cycle pulse per detected pattern occurrence.
REQ-012 match_count  out  COUNT_W  matches in current/last job; saturating.
REQ-013 done  out  1  one-cycle pulse at job end; match_count final when high.

Function
REQ-014 Pattern SHALL be fixed 6-bit 101011 (first bit first); overlapping occurrences SHALL all count.
REQ-015 States SHALL be IDLE, LOAD, SHIFT, DRAIN, DONE.
REQ-016 IDLE: start=1 -> LOAD; SHALL clear match_count to 0 and clear matcher progress in the same edge.
REQ-017 IDLE: start=0 -> stay; match_count holds last job result.
REQ-018 word_ready SHALL be 1 only in LOAD; transfer occurs when word_valid && word_ready.
REQ-019 LOAD: transfer -> SHIFT, latching word_in and word_last; no transfer -> stay, matcher holds progress.
REQ-020 SHIFT: exactly WORD_W cycles, one bit per cycle MSB-first into matcher with enable=1; matcher enable=0 in all other states.
REQ-021 After WORD_W-th bit: latched last=1 -> DRAIN, else -> LOAD; per-word cost WORD_W+1 cycles minimum.
REQ-022 Matcher progress SHALL persist across word boundaries and LOAD stalls within a job.
REQ-023 match_pulse SHALL be high the cycle after the enabled bit completing the pattern, for exactly one cycle, never during stalls.
REQ-024 match_count SHALL increment on the edge ending each match_pulse cycle; at 2^COUNT_W-1 it SHALL hold (no wrap).
REQ-025 DRAIN: one cycle (captures pulse from final bit) -> DONE.
REQ-026 DONE: done=1 for one cycle -> IDLE unconditionally.
REQ-027 start outside IDLE SHALL be ignored; word_valid outside LOAD SHALL be ignored.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, match_count=0, matcher progress cleared, shift counter 0.
REQ-029 Outputs during/after reset: word_ready=0, busy=0, match_pulse=0, done=0; mid-job reset abandons the job with no done pulse.

Structure
REQ-030 Shared package SHALL hold: state enum, PATTERN (6'b101011), PATTERN_LEN (6), default COUNT_W/WORD_W.
REQ-031 Sub-module pattern_matcher SHALL hold the 7-state bit matcher with ports clk, reset, clr, en, bit_in, hit (registered, one-cycle).
REQ-032 Shift counter SHALL be $clog2(WORD_W) bits; no combinational path from word_valid to word_ready.

Verification
REQ-033 Single word 0xAC, last=1 -> one match_pulse; done with match_count=1.
REQ-034 Words 0xAD then 0x60(last) -> two overlapping matches incl. cross-boundary; match_count=2.
REQ-035 Word 0xAD, then word_valid low 5 cycles in LOAD, then 0x60(last) -> still match_count=2, no extra pulses during stall.
REQ-036 260 words of 0xAC, last on final -> match_count saturates at 255 at done.
REQ-037 Reset asserted mid-SHIFT of second word -> immediate IDLE, match_count=0, no done; new job 0x00(last) -> done, match_count=0.
REQ-038 start pulsed during SHIFT and word_valid during SHIFT -> ignored; count unaffected.
